// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame controller.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    StHunt,
    StCmd,
    StAddr,
    StData,
    StCsum,
    StIssue
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_WR    = 8'h01;
  localparam logic [7:0] CMD_RD    = 8'h02;

  localparam logic [1:0] ERR_CMD  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

endpackage

// File: rtl/uart_cmd_timer.sv
// Saturating inter-byte timeout counter; expired is high while enabled and at the limit.
module uart_cmd_timer #(
  parameter int unsigned Limit = 17320
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int unsigned Width = $clog2(Limit + 1);
  localparam logic [Width-1:0] LimitW = Width'(Limit);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != LimitW)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = en && (count_q == LimitW);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command-frame parser: A5 CMD ADDR DATA [CSUM] -> register write/read request.
// Define UART_CMD_CSUM_EN to build the checksum byte and the CSUM state.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT  = 433,
  parameter int unsigned TIMEOUT_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       wr_en,
  output logic       rd_en,
  output logic [7:0] req_addr,
  output logic [7:0] req_data,
  input  logic       req_ready,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       overrun,
  output logic       busy
);
  localparam int unsigned TimeoutLimit = TIMEOUT_BYTES * 10 * CLKS_PER_BIT;

  state_e     state_q, state_d;
  logic       is_wr_q, is_wr_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [1:0] code_q, code_d;
  logic       err_q, err_d;
  logic       ovr_q, ovr_d;
  logic       wr_q, wr_d;
  logic       rd_q, rd_d;
  logic       busy_q, busy_d;
  logic       timer_clr, timer_en, expired;

  assign timer_en  = state_q inside {StCmd, StAddr, StData, StCsum};
  // A byte lost to a simultaneous timeout or to ISSUE is not an accepted byte.
  assign timer_clr = rx_valid && (state_q != StIssue) && !expired;

  uart_cmd_timer #(
    .Limit(TimeoutLimit)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .en     (timer_en),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StHunt;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    code_d  = code_q;
    err_d   = 1'b0;
    ovr_d   = 1'b0;
    if (expired) begin
      err_d   = 1'b1;
      code_d  = ERR_TMO;
      state_d = StHunt;
    end else begin
      unique case (state_q)
        StHunt: if (rx_valid && (rx_data == SYNC_BYTE)) state_d = StCmd;
        StCmd: if (rx_valid) begin
          if ((rx_data == CMD_WR) || (rx_data == CMD_RD)) begin
            is_wr_d = (rx_data == CMD_WR);
            state_d = StAddr;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_CMD;
            state_d = StHunt;
          end
        end
        StAddr: if (rx_valid) begin
          addr_d  = rx_data;
          state_d = StData;
        end
        StData: if (rx_valid) begin
          data_d = rx_data;
`ifdef UART_CMD_CSUM_EN
          state_d = StCsum;
`else
          state_d = StIssue;
`endif
        end
`ifdef UART_CMD_CSUM_EN
        StCsum: if (rx_valid) begin
          if (rx_data == ((is_wr_q ? CMD_WR : CMD_RD) ^ addr_q ^ data_q)) begin
            state_d = StIssue;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_CSUM;
            state_d = StHunt;
          end
        end
`endif
        StIssue: begin
          ovr_d = rx_valid;
          if (req_ready) state_d = StHunt;
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_comb begin
    wr_d   = 1'b0;
    rd_d   = 1'b0;
    busy_d = (state_d != StHunt);
    if (state_d == StIssue) begin
      wr_d = is_wr_d;
      rd_d = !is_wr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      busy_q <= busy_d;
      err_q  <= err_d;
      ovr_q  <= ovr_d;
    end
  end

  assign wr_en     = wr_q;
  assign rd_en     = rd_q;
  assign req_addr  = addr_q;
  assign req_data  = data_q;
  assign frame_err = err_q;
  assign err_code  = code_q;
  assign overrun   = ovr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: frame table plus multi-cycle corner sequences, scoreboard-checked.
// Honours UART_CMD_CSUM_EN to match the frame length of the build.
module tb_uart_cmd_ctrl;
  localparam int LIMIT = 4 * 10 * 433;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       req_ready = 1'b0;
  logic       wr_en, rd_en, frame_err, overrun, busy;
  logic [7:0] req_addr, req_data;
  logic [1:0] err_code;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       is_err;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [1:0] code;
  } ev_t;

  typedef struct {
    logic [47:0] raw;
    int          n;
    logic        has_ev;
    ev_t         ev;
  } vec_t;

  ev_t  ev_q[$];
  vec_t vecs[$];

  uart_cmd_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_ready(req_ready),
    .frame_err(frame_err),
    .err_code (err_code),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #10 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mon_event(input logic is_err);
    ev_t e;
    check("event_pending", 32'(ev_q.size() != 0), 1);
    if (ev_q.size() != 0) begin
      e = ev_q.pop_front();
      check("event_kind", 32'(is_err), 32'(e.is_err));
      if (!is_err) begin
        check("req_is_wr", 32'(wr_en), 32'(e.wr));
        check("req_addr", 32'(req_addr), 32'(e.addr));
        if (e.wr) check("req_data", 32'(req_data), 32'(e.data));
      end else begin
        check("err_code", 32'(err_code), 32'(e.code));
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en || rd_en) check("req_exclusive", 32'(wr_en & rd_en), 0);
      if ((wr_en || rd_en) && req_ready) mon_event(1'b0);
      if (frame_err) mon_event(1'b1);
    end
  end

  // Inputs only change 1 ns after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_req(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] d);
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(a);
    send_byte(d);
`ifdef UART_CMD_CSUM_EN
    send_byte(cmd ^ a ^ d);
`endif
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (ev_q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(ev_q.size()), 0);
  endtask

  function automatic ev_t mk_ev(input logic is_err, input logic wr, input logic [7:0] a,
                                input logic [7:0] d, input logic [1:0] code);
    ev_t e;
    e.is_err = is_err;
    e.wr     = wr;
    e.addr   = a;
    e.data   = d;
    e.code   = code;
    return e;
  endfunction

  function automatic vec_t mk(input logic [47:0] raw, input int n, input logic has_ev,
                              input ev_t e);
    vec_t v;
    v.raw    = raw;
    v.n      = n;
    v.has_ev = has_ev;
    v.ev     = e;
    return v;
  endfunction

  initial begin
    logic [1:0] last_code;
    logic [7:0] b;

`ifdef UART_CMD_CSUM_EN
    vecs.push_back(mk(48'hA5_01_10_5C_4D, 5, 1, mk_ev(0, 1, 8'h10, 8'h5C, 0)));
    vecs.push_back(mk(48'hA5_01_10_5C_00, 5, 1, mk_ev(1, 0, 0, 0, 2'd2)));
    vecs.push_back(mk(48'hA5_07, 2, 1, mk_ev(1, 0, 0, 0, 2'd1)));
    vecs.push_back(mk(48'hA5_02_20_00_22, 5, 1, mk_ev(0, 0, 8'h20, 8'h00, 0)));
    vecs.push_back(mk(48'h3C_A5_02_A5_7E_D9, 6, 1, mk_ev(0, 0, 8'hA5, 8'h7E, 0)));
    vecs.push_back(mk(48'hA5_02_20_00_23, 5, 1, mk_ev(1, 0, 0, 0, 2'd2)));
    vecs.push_back(mk(48'hA5_FF, 2, 1, mk_ev(1, 0, 0, 0, 2'd1)));
    vecs.push_back(mk(48'hA5_01_33_44_76, 5, 1, mk_ev(0, 1, 8'h33, 8'h44, 0)));
    vecs.push_back(mk(48'h5A_00_01, 3, 0, mk_ev(0, 0, 0, 0, 0)));
    last_code = 2'd1;
`else
    vecs.push_back(mk(48'hA5_01_10_5C, 4, 1, mk_ev(0, 1, 8'h10, 8'h5C, 0)));
    vecs.push_back(mk(48'hA5_07, 2, 1, mk_ev(1, 0, 0, 0, 2'd1)));
    vecs.push_back(mk(48'hA5_02_20_00, 4, 1, mk_ev(0, 0, 8'h20, 8'h00, 0)));
    vecs.push_back(mk(48'hA5_01_33_44, 4, 1, mk_ev(0, 1, 8'h33, 8'h44, 0)));
    vecs.push_back(mk(48'h3C_A5_02_A5_7E, 5, 1, mk_ev(0, 0, 8'hA5, 8'h7E, 0)));
    vecs.push_back(mk(48'hA5_00, 2, 1, mk_ev(1, 0, 0, 0, 2'd1)));
    vecs.push_back(mk(48'hA5_01_C3_0F, 4, 1, mk_ev(0, 1, 8'hC3, 8'h0F, 0)));
    vecs.push_back(mk(48'h5A_00_01, 3, 0, mk_ev(0, 0, 0, 0, 0)));
    last_code = 2'd1;
`endif

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req", 32'({wr_en, rd_en}), 0);
    check("rst_flags", 32'({frame_err, overrun, busy}), 0);
    check("rst_addr_data", 32'({req_addr, req_data}), 0);
    check("rst_err_code", 32'(err_code), 0);

    req_ready = 1'b1;
    foreach (vecs[i]) begin
      if (vecs[i].has_ev) ev_q.push_back(vecs[i].ev);
      for (int j = 0; j < vecs[i].n; j++) begin
        b = 8'(vecs[i].raw >> (8 * (vecs[i].n - 1 - j)));
        send_byte(b);
      end
      wait_drain("vec_drain");
      @(negedge clk);
      check("vec_idle", 32'({wr_en, rd_en, busy}), 0);
    end
    check("err_code_hold", 32'(err_code), 32'(last_code));

    // Read request stalled 7 cycles: rd_en high for 8.
    @(posedge clk); #1 req_ready = 1'b0;
    ev_q.push_back(mk_ev(0, 0, 8'h20, 8'h00, 0));
    send_req(8'h02, 8'h20, 8'h00);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("stall_rd_en", 32'(rd_en), 1);
      check("stall_addr", 32'(req_addr), 32'h20);
      @(posedge clk); #1 req_ready = (i == 6);
    end
    @(negedge clk);
    check("stall_drop", 32'({rd_en, busy}), 0);
    wait_drain("stall_drain");

    // Timeout in ADDR, with a byte landing on the firing edge.
    ev_q.push_back(mk_ev(1, 0, 0, 0, 2'd3));
    send_byte(8'hA5);
    send_byte(8'h01);
    @(negedge clk);
    check("tmo_busy", 32'(busy), 1);
    repeat (LIMIT - 1) @(posedge clk);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = 8'h11;
    @(posedge clk); #1 rx_valid = 1'b0;
    @(negedge clk);
    check("tmo_frame_err", 32'(frame_err), 1);
    check("tmo_err_code", 32'(err_code), 3);
    check("tmo_busy_low", 32'(busy), 0);
    @(negedge clk);
    check("tmo_pulse", 32'({frame_err, busy}), 0);
    wait_drain("tmo_drain");

    // Overrun while pending, then byte and acceptance together.
    ev_q.push_back(mk_ev(0, 1, 8'h55, 8'h66, 0));
    send_req(8'h01, 8'h55, 8'h66);
    @(negedge clk);
    check("ovr_wr_en", 32'(wr_en), 1);
    send_byte(8'h99);
    @(negedge clk);
    check("ovr_pulse", 32'(overrun), 1);
    check("ovr_req_held", 32'({wr_en, req_addr, req_data}), 32'h1_55_66);
    @(negedge clk);
    check("ovr_one_cycle", 32'(overrun), 0);
    @(posedge clk); #1;
    rx_valid  = 1'b1;
    rx_data   = 8'h42;
    req_ready = 1'b1;
    @(posedge clk); #1;
    rx_valid  = 1'b0;
    req_ready = 1'b0;
    @(negedge clk);
    check("ovr_accept", 32'({overrun, wr_en, busy}), 32'b100);
    wait_drain("ovr_drain");

    // Reset while a request is pending.
    send_req(8'h01, 8'h77, 8'h88);
    @(negedge clk);
    check("rst_pend_wr", 32'(wr_en), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_wr", 32'(wr_en), 0);
    check("rst_async_busy", 32'(busy), 0);
    check("rst_async_code", 32'(err_code), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_after", 32'({wr_en, rd_en, busy}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Frame-level controller behind the UART receiver. It consumes the byte stream (`data_valid`/`data`) produced by the receiver and parses fixed-format command frames. It issues register write and read requests to the on-chip register file over a valid/ready handshake, and flags malformed, stalled or overrun frames. It sits between the UART receiver and the register file/response path.

## Interface
- `CLKS_PER_BIT`, 433, clocks per UART bit; must match the receiver.
- `TIMEOUT_BYTES`, 4, inter-byte timeout in byte times. Timeout limit = `TIMEOUT_BYTES*10*CLKS_PER_BIT` clocks.
- `clk`  in  1  system clock, 50 MHz. One clock domain; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx_valid`  in  1  one-cycle byte strobe from the receiver.
- `rx_data`  in  8  received byte; valid only when `rx_valid`=1.
- `wr_en`  out  1  write request; held until accepted.
- `rd_en`  out  1  read request; held until accepted.
- `req_addr`  out  8  request address; stable while `wr_en`/`rd_en` is high.
- `req_data`  out  8  write data; stable while `wr_en` is high.
- `req_ready`  in  1  register file accepts the current request.
- `frame_err`  out  1  one-cycle error pulse.
- `err_code`  out  2  error cause: 1 bad cmd, 2 bad checksum, 3 timeout. Holds the last value.
- `overrun`  out  1  one-cycle pulse: byte dropped while a request was pending.
- `busy`  out  1  high in every state except HUNT.

## Operation
- Frame format: `0xA5`, CMD, ADDR, DATA, CSUM.
  - CMD `0x01` = write. CMD `0x02` = read; its DATA byte is ignored but still received.
- States: HUNT, CMD, ADDR, DATA, CSUM, ISSUE.
- HUNT: a byte `0xA5` -> CMD. Any other byte is discarded silently.
- CMD: `0x01`/`0x02` -> ADDR. Any other value -> `frame_err`, `err_code`=1, -> HUNT.
- ADDR: latch the byte into `req_addr` -> DATA.
- DATA: latch the byte into `req_data` -> CSUM.
- CSUM: compare the byte with CMD^ADDR^DATA (8-bit XOR).
  - Match -> ISSUE.
  - Mismatch -> `frame_err`, `err_code`=2, -> HUNT.
- ISSUE: `wr_en` (write) or `rd_en` (read) is high.
  - When `req_ready`=1 in a cycle, drop the request and go -> HUNT.
  - Never more than one of `wr_en`/`rd_en` is high.
- Timeout: a counter clears on every accepted `rx_valid` and on entry to CMD.
  - It increments in CMD..CSUM.
  - On reaching the limit: `frame_err`, `err_code`=3, -> HUNT.
  - It does not run in HUNT or ISSUE.
  - Counter width is `$clog2(limit+1)`; it saturates and never wraps.
- Overrun: `rx_valid` in ISSUE drops the byte and pulses `overrun`; the state is unchanged.
- `rx_valid` and `req_ready` in the same ISSUE cycle: the request completes, the byte is dropped, `overrun` pulses, the next state is HUNT.
- `rx_valid` in the same cycle the timeout fires: the timeout wins and the byte is discarded.
- A `0xA5` byte in CMD..CSUM is treated as ordinary data, not as a resync.

## Timing
- Reset values: state HUNT; `wr_en`, `rd_en`, `frame_err`, `overrun`, `busy` = 0; `req_addr`, `req_data`, `err_code` = 0; timeout counter 0.
- `rst` asserted mid-frame or mid-ISSUE: immediate return to HUNT. A pending request is withdrawn with no acceptance.
- All outputs are registered.
- Request latency: `wr_en`/`rd_en` rises in the cycle after the CSUM byte's `rx_valid`.
- Request handshake: a request is accepted on a clock edge where `wr_en|rd_en` and `req_ready` are both high. The request output is low in the following cycle.
- A request already asserted stays asserted until accepted (no timeout in ISSUE).
- `frame_err` and `err_code` update in the cycle after the triggering byte or timeout edge.

## Configuration
- `UART_CMD_CSUM_EN` defined: the 5-byte frame with a CSUM state, as above.
- Undefined: the frame is 4 bytes. DATA -> ISSUE directly, the CSUM state is not built, and `err_code`=2 never occurs.

## Structure
- Package `uart_cmd_pkg`:
  - state enum;
  - `SYNC_BYTE`=8'hA5, `CMD_WR`=8'h01, `CMD_RD`=8'h02;
  - error code constants `ERR_CMD`=2'd1, `ERR_CSUM`=2'd2, `ERR_TMO`=2'd3.
- One sub-module, `uart_cmd_timer`: the parameterised saturating timeout counter with clear/enable inputs and an `expired` output.

## Test plan
- A5 01 10 5C 4D, `req_ready` tied 1 -> single-cycle `wr_en` with `req_addr`=0x10, `req_data`=0x5C; no error; back to HUNT.
- A5 02 20 00 22, `req_ready` held 0 for 7 cycles -> `rd_en` high with `req_addr`=0x20 for 8 cycles; drops the cycle after acceptance.
- A5 01 10 5C 00 -> `frame_err`, `err_code`=2, no request. A following valid frame is then accepted.
- A5 07 -> `frame_err`, `err_code`=1. With the macro undefined, A5 01 33 44 -> `wr_en`, `req_addr`=0x33, `req_data`=0x44.
- A5 01 then silence for 4*10*433 clocks -> `frame_err`, `err_code`=3. Byte 0x11 arriving in the same cycle is discarded.
- Byte during ISSUE with `req_ready`=0 -> `overrun` pulse, request unchanged. `rst` pulse during ISSUE -> `wr_en`=0 immediately, `busy`=0.
